// File: rtl/utils_top.sv
// Shared RISC-V core definitions: major opcodes, load/store width
// encodings (funct3) and the memory-access FSM state type.
package utils_top;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP
   } mau_state_e;

   // Width encodings a load or store may legally use; the doubleword
   // and unsigned-word forms only exist on a 64-bit datapath.
   function automatic logic f3_legal(input logic [2:0] f3,
                                     input logic       is_st,
                                     input logic       x64);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_D:             ok = x64;
         F3_BU, F3_HU:     ok = ~is_st;
         F3_WU:            ok = x64 & ~is_st;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting for the memory-access stage.
// Request side (f3_i, is_st_i, off_i, sdat_i): legality/misalign check
//   err_o, byte enables be_o and lane-replicated store data sdat_o.
// Response side (ld_f3_i, ld_off_i, rdat_i): lane select plus sign or
//   zero extension of the load result, ldat_o.
module mem_lane_fmt
   import utils_top::*;
#(
   parameter  int XLEN  = 32,
   localparam int BE_W  = XLEN / 8,
   localparam int OFF_W = $clog2(BE_W)
) (
   input  logic [2:0]       f3_i,
   input  logic             is_st_i,
   input  logic [OFF_W-1:0] off_i,
   input  logic [XLEN-1:0]  sdat_i,
   output logic             err_o,
   output logic [BE_W-1:0]  be_o,
   output logic [XLEN-1:0]  sdat_o,
   input  logic [2:0]       ld_f3_i,
   input  logic [OFF_W-1:0] ld_off_i,
   input  logic [XLEN-1:0]  rdat_i,
   output logic [XLEN-1:0]  ldat_o
);

   localparam logic X64 = (XLEN == 64);

   logic [1:0]      sz;
   logic            mis;
   logic [BE_W-1:0] be_base;

   // Request side: size is funct3[1:0] (log2 of the byte count)
   always_comb begin
      sz      = f3_i[1:0];
      mis     = 1'b0;
      be_base = '0;
      sdat_o  = sdat_i;
      case (sz)
         2'd0: begin
            mis     = 1'b0;
            be_base = BE_W'(1);
            sdat_o  = {BE_W{sdat_i[7:0]}};
         end
         2'd1: begin
            mis     = off_i[0];
            be_base = BE_W'(3);
            sdat_o  = {(BE_W/2){sdat_i[15:0]}};
         end
         2'd2: begin
            mis     = |off_i[1:0];
            be_base = BE_W'(15);
            sdat_o  = {(BE_W/4){sdat_i[31:0]}};
         end
         default: begin
            mis     = |off_i;
            be_base = BE_W'(255);
            sdat_o  = sdat_i;
         end
      endcase
      err_o = mis | ~f3_legal(f3_i, is_st_i, X64);
      be_o  = be_base << off_i;
   end

   logic [XLEN-1:0] sh;
   logic [XLEN-1:0] mask;
   logic [XLEN-1:0] ext;
   logic [63:0]     m64;
   logic            sgn;

   // Response side: shift the addressed lane down to bit 0, keep only
   // the access width, then fill the upper bits from the lane's MSB
   // for the signed forms.
   always_comb begin
      sh  = rdat_i >> {ld_off_i, 3'b000};
      m64 = '1;
      sgn = 1'b0;
      case (ld_f3_i[1:0])
         2'd0: begin
            m64 = 64'h0000_0000_0000_00FF;
            sgn = sh[7];
         end
         2'd1: begin
            m64 = 64'h0000_0000_0000_FFFF;
            sgn = sh[15];
         end
         2'd2: begin
            m64 = 64'h0000_0000_FFFF_FFFF;
            sgn = sh[31];
         end
         default: begin
            m64 = '1;
            sgn = 1'b0;
         end
      endcase
      mask = m64[XLEN-1:0];
      ext  = sh & mask;
      if (!ld_f3_i[2] && sgn) begin
         ext = ext | ~mask;
      end
      ldat_o = ext;
   end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage between execute and writeback.
// ex_*: valid/ready instruction input; wb_*: registered one-cycle
// result pulse; mem_*: req/gnt request channel and rvalid response.
module memory_access_unit
   import utils_top::*;
#(
   parameter  int XLEN = 32,
   localparam int BE_W = XLEN / 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_vld,
   output logic            ex_rdy,
   input  logic [31:0]     ex_inst,
   input  logic [XLEN-1:0] ex_dat,
   input  logic [XLEN-1:0] ex_sdat,
   output logic            wb_vld,
   output logic [31:0]     wb_inst,
   output logic [XLEN-1:0] wb_dat,
   output logic            wb_err,
   output logic            mem_req,
   input  logic            mem_gnt,
   output logic            mem_wen,
   output logic [BE_W-1:0] mem_be,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_dat_in,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_dat_out
);

   localparam int OFF_W = $clog2(BE_W);
   localparam int HI_W  = XLEN - OFF_W;

   mau_state_e       state_q, state_d;
   logic             wb_vld_q, wb_vld_d;
   logic             wb_err_q, wb_err_d;
   logic [31:0]      wb_inst_q, wb_inst_d;
   logic [XLEN-1:0]  wb_dat_q, wb_dat_d;
   logic [31:0]      inst_q, inst_d;
   logic [OFF_W-1:0] off_q, off_d;
   logic [HI_W-1:0]  addr_hi_q, addr_hi_d;
   logic             wen_q, wen_d;
   logic [BE_W-1:0]  be_q, be_d;
   logic [XLEN-1:0]  mdat_q, mdat_d;

   logic            is_ld;
   logic            is_st;
   logic            f_err;
   logic [BE_W-1:0] f_be;
   logic [XLEN-1:0] f_sdat;
   logic [XLEN-1:0] f_ldat;

   assign is_ld = (ex_inst[6:0] == OP_LOAD);
   assign is_st = (ex_inst[6:0] == OP_STORE);

   // Load formatting uses the captured funct3/offset so the response
   // is independent of whatever execute presents meanwhile.
   mem_lane_fmt #(
      .XLEN(XLEN)
   ) u_fmt (
      .f3_i    (ex_inst[14:12]),
      .is_st_i (is_st),
      .off_i   (ex_dat[OFF_W-1:0]),
      .sdat_i  (ex_sdat),
      .err_o   (f_err),
      .be_o    (f_be),
      .sdat_o  (f_sdat),
      .ld_f3_i (inst_q[14:12]),
      .ld_off_i(off_q),
      .rdat_i  (mem_dat_out),
      .ldat_o  (f_ldat)
   );

   always_comb begin
      state_d   = state_q;
      wb_vld_d  = 1'b0;
      wb_err_d  = wb_err_q;
      wb_inst_d = wb_inst_q;
      wb_dat_d  = wb_dat_q;
      inst_d    = inst_q;
      off_d     = off_q;
      addr_hi_d = addr_hi_q;
      wen_d     = wen_q;
      be_d      = be_q;
      mdat_d    = mdat_q;
      case (state_q)
         IDLE: begin
            if (ex_vld) begin
               if ((is_ld || is_st) && !f_err) begin
                  state_d   = REQ;
                  inst_d    = ex_inst;
                  off_d     = ex_dat[OFF_W-1:0];
                  addr_hi_d = ex_dat[XLEN-1:OFF_W];
                  wen_d     = is_st;
                  be_d      = f_be;
                  mdat_d    = f_sdat;
               end else begin
                  wb_vld_d  = 1'b1;
                  wb_err_d  = (is_ld || is_st) && f_err;
                  wb_inst_d = ex_inst;
                  wb_dat_d  = ex_dat;
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               if (wen_q) begin
                  state_d   = IDLE;
                  wb_vld_d  = 1'b1;
                  wb_err_d  = 1'b0;
                  wb_inst_d = inst_q;
                  // the original effective address is ex_dat
                  wb_dat_d  = {addr_hi_q, off_q};
               end else begin
                  state_d = RSP;
               end
            end
         end
         RSP: begin
            if (mem_rvalid) begin
               state_d   = IDLE;
               wb_vld_d  = 1'b1;
               wb_err_d  = 1'b0;
               wb_inst_d = inst_q;
               wb_dat_d  = f_ldat;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wb_vld_q  <= 1'b0;
         wb_err_q  <= 1'b0;
         wb_inst_q <= '0;
         wb_dat_q  <= '0;
         inst_q    <= '0;
         off_q     <= '0;
         addr_hi_q <= '0;
         wen_q     <= 1'b0;
         be_q      <= '0;
         mdat_q    <= '0;
      end else begin
         state_q   <= state_d;
         wb_vld_q  <= wb_vld_d;
         wb_err_q  <= wb_err_d;
         wb_inst_q <= wb_inst_d;
         wb_dat_q  <= wb_dat_d;
         inst_q    <= inst_d;
         off_q     <= off_d;
         addr_hi_q <= addr_hi_d;
         wen_q     <= wen_d;
         be_q      <= be_d;
         mdat_q    <= mdat_d;
      end
   end

   assign ex_rdy     = (state_q == IDLE);
   assign mem_req    = (state_q == REQ);
   assign wb_vld     = wb_vld_q;
   assign wb_err     = wb_err_q;
   assign wb_inst    = wb_inst_q;
   assign wb_dat     = wb_dat_q;
   assign mem_wen    = wen_q;
   assign mem_be     = be_q;
   assign mem_addr   = {addr_hi_q, {OFF_W{1'b0}}};
   assign mem_dat_in = mdat_q;

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Parametrised, handshaked memory-access pipeline stage between execute and writeback. It supersedes the single-cycle, always-selected memory access. It adds sub-word loads and stores (byte, halfword, word, and doubleword at XLEN=64) with byte enables, sign or zero extension, and misalignment detection. It also adds a request/grant/response memory protocol with variable latency, during which the stage stalls execute.

## Interface
- XLEN, 32, data/address width; legal values 32 and 64
- BE_W, XLEN/8, byte-enable width (derived, not overridable)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_vld  in  1  execute presents an instruction
- ex_rdy  out  1  stage accepts; transfer when ex_vld&ex_rdy
- ex_inst  in  32  instruction (opcode [6:0], funct3 [14:12])
- ex_dat  in  XLEN  ALU result; the effective address for loads and stores
- ex_sdat  in  XLEN  store data (rs2)
- wb_vld  out  1  one-cycle pulse, result valid
- wb_inst  out  32  instruction being retired to writeback
- wb_dat  out  XLEN  load data (formatted) or ex_dat
- wb_err  out  1  misaligned or unsupported-width access; no memory traffic was issued
- mem_req  out  1  request; held until mem_gnt
- mem_gnt  in  1  request accepted this cycle
- mem_wen  out  1  1=store
- mem_be  out  BE_W  byte enables
- mem_addr  out  XLEN  address aligned to XLEN/8 (low log2(BE_W) bits zero)
- mem_dat_in  out  XLEN  store data, lane-steered
- mem_rvalid  in  1  load response valid
- mem_dat_out  in  XLEN  load response data

## Operation
- FSM states:
  - IDLE → REQ on accepting a valid, aligned load or store.
  - REQ → RSP (load) or IDLE (store) on mem_gnt.
  - RSP → IDLE on mem_rvalid.
  - Non-memory, misaligned and unsupported instructions never leave IDLE.
- ex_rdy = (state==IDLE). Execute stalls otherwise.
- Width by funct3:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - At XLEN=64 only: 011 D, 110 WU.
  - Any other funct3, including 111, sets wb_err.
- Misalignment: H/HU with addr[0]≠0; W/WU with addr[1:0]≠0; D with addr[2:0]≠0. Sets wb_err; no mem_req; wb_dat=ex_dat.
- Stores:
  - Data is replicated across lanes: byte×BE_W, half×BE_W/2, word×BE_W/4.
  - mem_be is 1, 3, 0xF or 0xFF shifted left by addr offset.
- Loads: select the lane at addr offset from mem_dat_out, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to XLEN.
- Stores and non-memory instructions: wb_dat=ex_dat.
- mem_addr, mem_wen, mem_be and mem_dat_in come from a request register captured at accept. They are stable for the whole of REQ and RSP.
- mem_rvalid outside RSP is ignored. mem_gnt outside REQ is ignored.

## Timing
- Accept at cycle T.
- Non-memory, misaligned or unsupported: wb_vld at T+1.
- Store: mem_req from T+1. If mem_gnt arrives at cycle G, wb_vld at G+1 and ex_rdy high at G+1.
- Load: mem_req from T+1 until gnt at G. State is RSP from G+1. mem_rvalid at R≥G+1 gives wb_vld at R+1 with the formatted data. Minimum load latency is 3.
- Back-to-back: the stage can accept in the same cycle wb_vld is asserted for the previous instruction.
- All wb_* outputs are registered and hold their values between pulses.
- Reset values: state IDLE, ex_rdy 1, wb_vld 0, wb_err 0, wb_inst 0, wb_dat 0, mem_req 0, mem_wen 0, mem_be 0, mem_addr 0, mem_dat_in 0.
- Reset mid-transaction abandons it. A later mem_gnt or mem_rvalid for that transaction is ignored, because the FSM is in IDLE.

## Structure
- Shared package utils_top gains:
  - funct3 width constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - the state typedef enum (IDLE, REQ, RSP).
- OP_LOAD and OP_STORE are reused from utils_top.
- One combinational sub-module, mem_lane_fmt: it holds store replication, byte-enable generation, load lane selection and extension, and the misalign/unsupported check.

## Test plan
- ALU op (opcode 0110011), ex_dat=0x1234 → wb_vld at T+1, wb_dat=0x1234, mem_req never asserted.
- SB, addr=0x1003, sdat=0xAB, gnt at T+1 → mem_be=4'b1000, mem_dat_in=0xABABABAB, mem_addr=0x1000, wb_vld at T+2.
- LB, addr=0x2002, gnt after 3 cycles, rdata=0x00800000 → wb_dat=0xFFFFFF80. LBU with the same stimulus → wb_dat=0x00000080.
- LW, addr=0x2002 → wb_err=1 at T+1, no mem_req.
- LH, addr=0x10; rst asserted during RSP, then rvalid → no wb_vld, all outputs at reset values.
- XLEN=64: SD, addr=0x8, sdat=0x0123456789ABCDEF → mem_be=0xFF, wb_vld after gnt. funct3 011 at XLEN=32 → wb_err=1.
